// File: rtl/dlfloat_pkg.sv
// Shared DLFloat16 constants and the byte-assembly state type.
package dlfloat_pkg;

  localparam int DLF_W = 16;
  localparam logic [DLF_W-1:0] DLF_NAN  = 16'hFFFF;
  localparam logic [DLF_W-1:0] DLF_ZERO = 16'h0000;

  typedef enum logic [0:0] {
    HI_WAIT = 1'b0,
    LO_WAIT = 1'b1
  } dlf_state_e;

endpackage

// File: rtl/dlfloat_result_collector_sync_fifo.sv
// Synchronous FIFO: head is read straight from storage registers, zero when empty.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    count_q, count_d;
  logic             pop_en;
  logic             push_en;

  // A full FIFO still takes a push when a pop frees the slot in the same cycle.
  always_comb begin
    pop_en   = pop && !empty;
    push_en  = push && (!full || pop_en);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_en) begin
      wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_en) begin
      rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (push_en && !pop_en) begin
      count_d = count_q + {{(LW-1){1'b0}}, 1'b1};
    end else if (pop_en && !push_en) begin
      count_d = count_q - {{(LW-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {LW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en && !rst) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  assign empty = (count_q == {LW{1'b0}});
  assign full  = (count_q == LW'(DEPTH));
  assign level = count_q;
  assign dout  = empty ? {WIDTH{1'b0}} : mem_q[rd_ptr_q];

endmodule

// File: rtl/dlfloat_result_collector.sv
// Reassembles byte-serialized DLFloat16 results (high byte first) into a FIFO
// with NaN/zero head decode and sticky overflow/resync error flags.
module dlfloat_result_collector
  import dlfloat_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               byte_in,
  input  logic                     byte_valid,
  input  logic                     frame_start,
  output logic [DLF_W-1:0]         word_out,
  output logic                     word_valid,
  input  logic                     word_ready,
  output logic                     is_nan,
  output logic                     is_zero,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     resync_err
);

  dlf_state_e       state_q, state_d;
  logic [7:0]       hi_q, hi_d;
  logic             overflow_q;
  logic             resync_q;
  logic             push;
  logic             resync;
  logic             full;
  logic             empty;
  logic [DLF_W-1:0] head;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= HI_WAIT;
      hi_q       <= 8'h00;
      overflow_q <= 1'b0;
      resync_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      hi_q       <= hi_d;
      overflow_q <= overflow_q | (push && full && !(word_ready && !empty));
      resync_q   <= resync_q | resync;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      HI_WAIT: begin
        if (byte_valid) state_d = LO_WAIT;
        else            state_d = HI_WAIT;
      end
      LO_WAIT: begin
        if (byte_valid && !frame_start) state_d = HI_WAIT;
        else                            state_d = LO_WAIT;
      end
      default: state_d = HI_WAIT;
    endcase
  end

  // frame_start in LO_WAIT restarts the frame with the new byte as high byte.
  always_comb begin
    push   = 1'b0;
    resync = 1'b0;
    hi_d   = hi_q;
    case (state_q)
      HI_WAIT: begin
        if (byte_valid) hi_d = byte_in;
        else            hi_d = hi_q;
      end
      LO_WAIT: begin
        if (byte_valid && frame_start) begin
          hi_d   = byte_in;
          resync = 1'b1;
        end else if (byte_valid) begin
          push = 1'b1;
        end else begin
          hi_d = hi_q;
        end
      end
      default: begin
        push   = 1'b0;
        resync = 1'b0;
      end
    endcase
  end

  sync_fifo #(
    .WIDTH (DLF_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   ({hi_q, byte_in}),
    .pop   (word_ready),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign word_out   = head;
  assign word_valid = !empty;
  assign is_nan     = !empty && (head == DLF_NAN);
  assign is_zero    = !empty && (head == DLF_ZERO);
  assign overflow   = overflow_q;
  assign resync_err = resync_q;

endmodule

// File: tb/tb_dlfloat_result_collector.sv
// Directed bench with a word scoreboard; every cycle checks head, level and flags.
module tb_dlfloat_result_collector;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic        frame_start = 1'b0;
  logic [15:0] word_out;
  logic        word_valid;
  logic        word_ready = 1'b0;
  logic        is_nan;
  logic        is_zero;
  logic [2:0]  level;
  logic        overflow;
  logic        resync_err;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] sb_q[$];
  logic        exp_ovf = 1'b0;
  logic        exp_rse = 1'b0;

  dlfloat_result_collector #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .byte_in     (byte_in),
    .byte_valid  (byte_valid),
    .frame_start (frame_start),
    .word_out    (word_out),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .is_nan      (is_nan),
    .is_zero     (is_zero),
    .level       (level),
    .overflow    (overflow),
    .resync_err  (resync_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    logic [15:0] eh;
    eh = (sb_q.size() > 0) ? sb_q[0] : 16'h0000;
    chk("level", 32'(level), 32'(sb_q.size()));
    chk("word_valid", 32'(word_valid), 32'(sb_q.size() > 0));
    chk("word_out", 32'(word_out), 32'(eh));
    chk("is_nan", 32'(is_nan), 32'((sb_q.size() > 0) && (eh == 16'hFFFF)));
    chk("is_zero", 32'(is_zero), 32'((sb_q.size() > 0) && (eh == 16'h0000)));
    chk("overflow", 32'(overflow), 32'(exp_ovf));
    chk("resync_err", 32'(resync_err), 32'(exp_rse));
  endtask

  // One clock: cpl says the bench knows this byte completes word w.
  task automatic cycle(input logic v, input logic fs, input logic [7:0] b,
                       input logic rdy, input logic cpl, input logic [15:0] w);
    byte_valid  = v;
    frame_start = fs;
    byte_in     = b;
    word_ready  = rdy;
    if (rdy && sb_q.size() > 0) begin
      chk("popped_word", 32'(word_out), 32'(sb_q[0]));
      void'(sb_q.pop_front());
    end
    if (cpl) begin
      if (sb_q.size() < DEPTH) sb_q.push_back(w);
      else exp_ovf = 1'b1;
    end
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
    word_ready = 1'b0;
    check_state();
  endtask

  task automatic send_word(input logic [15:0] w, input logic rdy);
    cycle(1'b1, 1'b1, w[15:8], rdy, 1'b0, 16'h0000);
    cycle(1'b1, 1'b0, w[7:0], rdy, 1'b1, w);
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    byte_valid  = 1'b1;
    frame_start = 1'b0;
    byte_in     = 8'h99;
    word_ready  = 1'b1;
    @(posedge clk);
    #1;
    rst        = 1'b0;
    byte_valid = 1'b0;
    word_ready = 1'b0;
    sb_q.delete();
    exp_ovf = 1'b0;
    exp_rse = 1'b0;
    check_state();
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 16'h0000);
  endtask

  initial begin
    do_reset();
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000);

    // Single word with ready: visible one cycle, then consumed.
    send_word(16'h3E00, 1'b1);
    chk("req033_valid", 32'(word_valid), 32'd1);
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 16'h0000);
    chk("req033_gone", 32'(word_valid), 32'd0);

    // NaN then zero.
    send_word(16'hFFFF, 1'b0);
    send_word(16'h0000, 1'b0);
    chk("req034_nan", 32'(is_nan), 32'd1);
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 16'h0000);
    chk("req034_zero", 32'(is_zero), 32'd1);
    drain();

    // Overflow with five words, then push+pop when full.
    for (int k = 1; k <= 5; k++) send_word(16'(k), 1'b0);
    chk("req035_ovf", 32'(overflow), 32'd1);
    chk("req035_level", 32'(level), 32'd4);
    cycle(1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 16'h0000);
    cycle(1'b1, 1'b0, 8'h06, 1'b1, 1'b1, 16'h0006);
    chk("req036_level", 32'(level), 32'd4);
    drain();

    // Resync: AA discarded, 41 becomes high byte; idle in between holds state.
    do_reset();
    cycle(1'b1, 1'b1, 8'hAA, 1'b0, 1'b0, 16'h0000);
    cycle(1'b0, 1'b0, 8'h55, 1'b0, 1'b0, 16'h0000);
    exp_rse = 1'b1;
    cycle(1'b1, 1'b1, 8'h41, 1'b0, 1'b0, 16'h0000);
    cycle(1'b0, 1'b1, 8'h77, 1'b0, 1'b0, 16'h0000);
    cycle(1'b1, 1'b0, 8'h80, 1'b0, 1'b1, 16'h4180);
    chk("req037_word", 32'(word_out), 32'h4180);
    drain();

    // Reset mid-frame discards the held high byte.
    cycle(1'b1, 1'b1, 8'h12, 1'b0, 1'b0, 16'h0000);
    do_reset();
    cycle(1'b1, 1'b0, 8'h34, 1'b0, 1'b0, 16'h0000);
    cycle(1'b1, 1'b0, 8'h56, 1'b0, 1'b1, 16'h3456);
    chk("req038_word", 32'(word_out), 32'h3456);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
